// File: rtl/mega_jsoc_mem_pkg.sv
// Shared constants for the JSOC on-chip memory arbiter.
// Bus width defaults, byte-enable width helper and owner tags.
package mega_jsoc_mem_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 32;
   localparam int MAX_HOLD_DEF = 4;

   // Tag recorded with a pending read to steer its return data.
   localparam logic OWN_M0 = 1'b0;
   localparam logic OWN_M1 = 1'b1;

   function automatic int be_width(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/mega_jsoc_rr_grant.sv
// Two-way round-robin grant with a bounded hold count per master.
// Ports: clk, rst, req[1:0] in; grant[1:0], gnt_any, gnt_idx out.
module mega_jsoc_rr_grant
   import mega_jsoc_mem_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       gnt_any,
   output logic       gnt_idx
);

   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

   logic          last;
   logic          last_valid;
   logic [HW-1:0] hold_cnt;
   logic          other;
   logic          cont;
   logic [1:0]    grant_c;

   // The current owner keeps the bus while its run is short or the
   // other master is idle; otherwise the other master takes over.
   always_comb begin
      other   = ~last;
      cont    = last_valid & req[last] &
                ((hold_cnt < HOLD_TOP) | ~req[other]);
      grant_c = 2'b00;
      unique case (1'b1)
         cont:
            grant_c[last] = 1'b1;
         (~cont & req[other]):
            grant_c[other] = 1'b1;
         (~cont & ~req[other] & req[last]):
            grant_c[last] = 1'b1;
         default: ;
      endcase
   end

   // No grant can escape while reset is held.
   assign grant   = rst ? 2'b00 : grant_c;
   assign gnt_any = |grant;
   assign gnt_idx = grant[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last       <= 1'b1;
         last_valid <= 1'b0;
         hold_cnt   <= '0;
      end else if (gnt_any) begin
         if (last_valid && (gnt_idx == last)) begin
            if (hold_cnt != HOLD_TOP)
               hold_cnt <= hold_cnt + 1'b1;
         end else begin
            hold_cnt <= '0;
         end
         last       <= gnt_idx;
         last_valid <= 1'b1;
      end else begin
         last_valid <= 1'b0;
         hold_cnt   <= '0;
      end
   end

endmodule

// File: rtl/mega_jsoc_onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters.
// Ports: m0_*/m1_* slave sides, mem_* RAM side, clk, reset.
module mega_jsoc_onchip_mem_arbiter
   import mega_jsoc_mem_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                clk,
   input  logic                reset,

   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,

   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,

   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int BE_W = be_width(DATA_W);

   logic [1:0]        req;
   logic [1:0]        grant;
   logic              gnt_any;
   logic              gnt_idx;
   logic              sel_wr;
   logic [BE_W-1:0]   sel_be;
   logic              rd_pend;
   logic              rd_owner;

   // A write beat with read also asserted is treated as a write.
   assign req = {m1_read | m1_write, m0_read | m0_write};

   mega_jsoc_rr_grant #(
      .MAX_HOLD (MAX_HOLD)
   ) u_grant (
      .clk     (clk),
      .rst     (reset),
      .req     (req),
      .grant   (grant),
      .gnt_any (gnt_any),
      .gnt_idx (gnt_idx)
   );

   assign m0_waitrequest = reset | (req[0] & ~grant[0]);
   assign m1_waitrequest = reset | (req[1] & ~grant[1]);

   always_comb begin
      sel_wr        = gnt_idx ? m1_write      : m0_write;
      sel_be        = gnt_idx ? m1_byteenable : m0_byteenable;
      mem_address   = gnt_idx ? m1_address    : m0_address;
      mem_writedata = gnt_idx ? m1_writedata  : m0_writedata;
   end

   // Reads always fetch the full word; lanes matter only for writes.
   assign mem_byteenable = sel_wr ? sel_be : {BE_W{1'b1}};
   assign mem_write      = gnt_any & sel_wr;
   assign mem_chipselect = gnt_any;
   assign mem_clken      = ~reset;

   // RAM q arrives one cycle after the address; remember who asked.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend  <= 1'b0;
         rd_owner <= OWN_M0;
      end else begin
         rd_pend  <= gnt_any & ~sel_wr;
         rd_owner <= gnt_idx;
      end
   end

   assign m0_readdatavalid = rd_pend & (rd_owner == OWN_M0);
   assign m1_readdatavalid = rd_pend & (rd_owner == OWN_M1);
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_mega_jsoc_onchip_mem_arbiter.sv
// Self-checking bench for mega_jsoc_onchip_mem_arbiter.
// Bench-side RAM plus a run-length arbitration reference model.
module tb_mega_jsoc_onchip_mem_arbiter;

   localparam int AW = 14;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int MH = 4;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          rd [2];
   logic          wr [2];
   logic [AW-1:0] ad [2];
   logic [BW-1:0] be [2];
   logic [DW-1:0] wd [2];

   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_byteenable;
   logic          mem_chipselect, mem_write, mem_clken;
   logic [DW-1:0] mem_writedata;
   logic [DW-1:0] mem_q;

   mega_jsoc_onchip_mem_arbiter #(
      .ADDR_W (AW), .DATA_W (DW), .MAX_HOLD (MH)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (ad[0]),
      .m0_read          (rd[0]),
      .m0_write         (wr[0]),
      .m0_byteenable    (be[0]),
      .m0_writedata     (wd[0]),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (ad[1]),
      .m1_read          (rd[1]),
      .m1_write         (wr[1]),
      .m1_byteenable    (be[1]),
      .m1_writedata     (wd[1]),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_q)
   );

   // Single-port RAM with one cycle read latency.
   logic [DW-1:0] ram [DEPTH];
   logic          init_req = 1'b1;

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < DEPTH; i++)
            ram[i] <= DW'(i) ^ 32'hA5A5_0000;
      end else if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            for (int b = 0; b < BW; b++)
               if (mem_byteenable[b])
                  ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end
         mem_q <= ram[mem_address];
      end
   end

   // Reference state: expected memory image and arbitration history.
   logic [DW-1:0] ref_mem [DEPTH];
   int            m_last;
   bit            m_prevg;
   int            m_streak;
   bit            x_pend;
   int            x_owner;
   logic [DW-1:0] x_data;
   int            obs_acc [2];
   int            obs_rdv [2];

   int checks = 0;
   int failures = 0;

   task automatic set_idle();
      for (int m = 0; m < 2; m++) begin
         rd[m] = 1'b0;
         wr[m] = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_last   = 1;
      m_prevg  = 1'b0;
      m_streak = 0;
      x_pend   = 1'b0;
   endtask

   // One bus cycle: predict, compare, update model, advance clock.
   task automatic cycle(output int mg, output int og);
      int q [2];
      int g;
      bit w;
      bit e0, e1;
      #1;
      q[0] = int'(rd[0] | wr[0]);
      q[1] = int'(rd[1] | wr[1]);
      g = -1;
      if (m_prevg && q[m_last] != 0 &&
          (m_streak < MH || q[1-m_last] == 0))
         g = m_last;
      else if (q[1-m_last] != 0)
         g = 1 - m_last;
      else if (q[m_last] != 0)
         g = m_last;

      og = -1;
      if (q[0] != 0 && !m0_waitrequest) og = 0;
      else if (q[1] != 0 && !m1_waitrequest) og = 1;
      if (q[0] != 0 && !m0_waitrequest) obs_acc[0]++;
      if (q[1] != 0 && !m1_waitrequest) obs_acc[1]++;

      e0 = (q[0] != 0) && (g != 0);
      e1 = (q[1] != 0) && (g != 1);
      checks++;
      if (m0_waitrequest !== e0) begin
         failures++;
         $display("FAIL m0_waitrequest: got %b want %b t=%0t",
                  m0_waitrequest, e0, $time);
      end
      checks++;
      if (m1_waitrequest !== e1) begin
         failures++;
         $display("FAIL m1_waitrequest: got %b want %b t=%0t",
                  m1_waitrequest, e1, $time);
      end
      checks++;
      if (mem_chipselect !== (g >= 0) || mem_clken !== 1'b1) begin
         failures++;
         $display("FAIL chipselect/clken: got %b/%b want %b/1 t=%0t",
                  mem_chipselect, mem_clken, g >= 0, $time);
      end
      if (g >= 0) begin
         w = wr[g];
         checks++;
         if (mem_write !== w || mem_address !== ad[g]) begin
            failures++;
            $display("FAIL mem_cmd: got w=%b a=%h want w=%b a=%h",
                     mem_write, mem_address, w, ad[g]);
         end
         checks++;
         if (mem_byteenable !== (w ? be[g] : 4'hF)) begin
            failures++;
            $display("FAIL mem_byteenable: got %h want %h",
                     mem_byteenable, w ? be[g] : 4'hF);
         end
         if (w) begin
            checks++;
            if (mem_writedata !== wd[g]) begin
               failures++;
               $display("FAIL mem_writedata: got %h want %h",
                        mem_writedata, wd[g]);
            end
         end
      end else begin
         checks++;
         if (mem_write !== 1'b0) begin
            failures++;
            $display("FAIL mem_write_idle: got %b want 0", mem_write);
         end
      end

      e0 = x_pend && x_owner == 0;
      e1 = x_pend && x_owner == 1;
      if (m0_readdatavalid) obs_rdv[0]++;
      if (m1_readdatavalid) obs_rdv[1]++;
      checks++;
      if (m0_readdatavalid !== e0 || m1_readdatavalid !== e1) begin
         failures++;
         $display("FAIL readdatavalid: got %b%b want %b%b t=%0t",
                  m1_readdatavalid, m0_readdatavalid, e1, e0, $time);
      end
      if (x_pend) begin
         checks++;
         if ((x_owner == 0 ? m0_readdata : m1_readdata) !== x_data) begin
            failures++;
            $display("FAIL readdata: got %h want %h t=%0t",
                     x_owner == 0 ? m0_readdata : m1_readdata,
                     x_data, $time);
         end
      end

      x_pend = 1'b0;
      if (g >= 0) begin
         if (wr[g]) begin
            for (int b = 0; b < BW; b++)
               if (be[g][b])
                  ref_mem[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
         end else begin
            x_pend  = 1'b1;
            x_owner = g;
            x_data  = ref_mem[ad[g]];
         end
         m_streak = (m_prevg && g == m_last) ? m_streak + 1 : 1;
         m_last   = g;
         m_prevg  = 1'b1;
      end else begin
         m_prevg  = 1'b0;
         m_streak = 0;
      end
      mg = g;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rd[0] = 1'b1;
      wr[1] = 1'b1;
      #1;
      checks++;
      if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL rst_waitrequest: got %b%b want 11",
                  m1_waitrequest, m0_waitrequest);
      end
      checks++;
      if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
         failures++;
         $display("FAIL rst_readdatavalid: got %b%b want 00",
                  m1_readdatavalid, m0_readdatavalid);
      end
      checks++;
      if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 ||
          mem_clken !== 1'b0) begin
         failures++;
         $display("FAIL rst_mem: got cs=%b w=%b ck=%b want 0 0 0",
                  mem_chipselect, mem_write, mem_clken);
      end
      @(posedge clk);
      #1;
      set_idle();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      int mg, og;
      set_idle();
      do_reset();
      cycle(mg, og);
   endtask

   task automatic test_write_read();
      int mg, og;
      set_idle();
      do_reset();
      wr[0] = 1'b1; ad[0] = 14'h0010; be[0] = 4'hF; wd[0] = 32'hDEADBEEF;
      cycle(mg, og);
      checks++;
      if (og != 0) begin
         failures++;
         $display("FAIL wr_accept: got %0d want 0", og);
      end
      wr[0] = 1'b0; rd[0] = 1'b1;
      cycle(mg, og);
      checks++;
      if (og != 0) begin
         failures++;
         $display("FAIL rd_accept: got %0d want 0", og);
      end
      set_idle();
      checks++;
      if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rd_return: got v=%b d=%h want 1 deadbeef",
                  m0_readdatavalid, m0_readdata);
      end
      cycle(mg, og);
   endtask

   task automatic test_round_robin();
      int mg, og;
      set_idle();
      do_reset();
      obs_acc[0] = 0; obs_acc[1] = 0;
      obs_rdv[0] = 0; obs_rdv[1] = 0;
      ad[0] = 14'h0000; ad[1] = 14'h2000;
      rd[0] = 1'b1; rd[1] = 1'b1;
      for (int k = 0; k < 24; k++) begin
         cycle(mg, og);
         checks++;
         if (og != (k / 4) % 2) begin
            failures++;
            $display("FAIL rr_pattern[%0d]: got %0d want %0d",
                     k, og, (k / 4) % 2);
         end
         if (mg >= 0) ad[mg] = ad[mg] + 1'b1;
      end
      set_idle();
      cycle(mg, og);
      checks++;
      if (obs_acc[0] != 12 || obs_acc[1] != 12 ||
          obs_rdv[0] != 12 || obs_rdv[1] != 12) begin
         failures++;
         $display("FAIL rr_counts: got acc %0d/%0d rdv %0d/%0d want 12",
                  obs_acc[0], obs_acc[1], obs_rdv[0], obs_rdv[1]);
      end
   endtask

   task automatic test_m1_alone();
      int mg, og;
      set_idle();
      cycle(mg, og);
      rd[1] = 1'b1; ad[1] = 14'h0100;
      for (int k = 0; k < 10; k++) begin
         cycle(mg, og);
         checks++;
         if (og != 1) begin
            failures++;
            $display("FAIL m1_alone[%0d]: got %0d want 1", k, og);
         end
         ad[1] = ad[1] + 1'b1;
      end
      rd[0] = 1'b1; ad[0] = 14'h0200;
      cycle(mg, og);
      checks++;
      if (og != 0) begin
         failures++;
         $display("FAIL m0_takeover: got %0d want 0", og);
      end
      set_idle();
      cycle(mg, og);
   endtask

   task automatic test_byte_lanes();
      int mg, og;
      set_idle();
      wr[0] = 1'b1; ad[0] = 14'h0040; be[0] = 4'hF; wd[0] = 32'h11223344;
      cycle(mg, og);
      set_idle();
      wr[1] = 1'b1; ad[1] = 14'h0040; be[1] = 4'h5; wd[1] = 32'hAABBCCDD;
      cycle(mg, og);
      set_idle();
      rd[0] = 1'b1;
      cycle(mg, og);
      set_idle();
      checks++;
      if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h11BB33DD) begin
         failures++;
         $display("FAIL byte_lanes: got v=%b d=%h want 1 11bb33dd",
                  m0_readdatavalid, m0_readdata);
      end
      cycle(mg, og);
   endtask

   task automatic test_simultaneous();
      int mg, og;
      set_idle();
      do_reset();
      rd[0] = 1'b1; ad[0] = 14'h0300;
      rd[1] = 1'b1; ad[1] = 14'h0301;
      cycle(mg, og);
      checks++;
      if (og != 0) begin
         failures++;
         $display("FAIL simul_first: got %0d want 0", og);
      end
      rd[0] = 1'b0;
      cycle(mg, og);
      checks++;
      if (og != 1) begin
         failures++;
         $display("FAIL simul_second: got %0d want 1", og);
      end
      set_idle();
      cycle(mg, og);
   endtask

   task automatic test_reset_mid();
      int mg, og;
      set_idle();
      rd[0] = 1'b1; ad[0] = 14'h0005;
      cycle(mg, og);
      rd[1] = 1'b1; ad[1] = 14'h0006;
      reset = 1'b1;
      #1;
      checks++;
      if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst_rdv: got %b%b want 00",
                  m1_readdatavalid, m0_readdatavalid);
      end
      checks++;
      if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL mid_rst_wait: got %b%b want 11",
                  m1_waitrequest, m0_waitrequest);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      cycle(mg, og);
      checks++;
      if (og != 0) begin
         failures++;
         $display("FAIL mid_rst_restart: got %0d want 0", og);
      end
      set_idle();
      cycle(mg, og);
   endtask

   task automatic test_random();
      int mg, og;
      int p;
      for (int k = 0; k < 300; k++) begin
         for (int m = 0; m < 2; m++) begin
            p = int'($urandom_range(0, 15));
            rd[m] = (p >= 4 && p < 10) || p == 15;
            wr[m] = (p >= 10);
            ad[m] = AW'($urandom_range(0, 15));
            be[m] = BW'($urandom);
            wd[m] = $urandom;
         end
         cycle(mg, og);
      end
      set_idle();
      cycle(mg, og);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++)
         ref_mem[i] = DW'(i) ^ 32'hA5A5_0000;
      for (int m = 0; m < 2; m++) begin
         ad[m] = '0;
         be[m] = '0;
         wd[m] = '0;
      end
      set_idle();
      model_reset();
      @(posedge clk);
      #1;
      init_req = 1'b0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_m1_alone();
      test_byte_lanes();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mega_jsoc_onchip_mem_arbiter.md
Name: mega_jsoc_onchip_mem_arbiter

Overview:
- Shares one single-port on-chip RAM between two Avalon-MM masters (m0, m1), e.g. two CPU data masters.
- Arbitration is zero-latency, round-robin, with a bounded hold count per master.
- Drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs.
- Routes the RAM's one-cycle-latency read data back to the master that issued the read, using readdatavalid.

Parameters:
- ADDR_W, 14, word address width of the RAM.
- DATA_W, 32, data width; BE_W = DATA_W/8.
- MAX_HOLD, 4, maximum consecutive beats one master keeps the grant while the other master is requesting (must be >= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mN_address  in  ADDR_W  word address of master N (N = 0, 1).
- mN_read  in  1  read request of master N.
- mN_write  in  1  write request of master N.
- mN_byteenable  in  BE_W  write byte lanes of master N.
- mN_writedata  in  DATA_W  write data of master N.
- mN_waitrequest  out  1  master N's request was not accepted this cycle.
- mN_readdata  out  DATA_W  read data to master N.
- mN_readdatavalid  out  1  mN_readdata is valid this cycle.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  BE_W  RAM byte enables.
- mem_chipselect  out  1  RAM chip select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable.
- mem_readdata  in  DATA_W  RAM q; valid the cycle after the address is accepted.

Behaviour:
- reqN = mN_read | mN_write. mN_read together with mN_write is illegal; the write is performed and the read is ignored.
- Registered state: last (0/1), last_valid, hold_cnt (saturating at MAX_HOLD-1), rd_pend, rd_owner.
- Reset values: last=1 (so m0 wins the first arbitration), last_valid=0, hold_cnt=0, rd_pend=0.
- While reset is high: both waitrequest outputs = 1, both readdatavalid outputs = 0, mem_chipselect = 0, mem_write = 0.
- Grant (combinational each cycle): other = ~last; cont = last_valid & req[last] & (hold_cnt < MAX_HOLD-1 | ~req[other]).
- Grant priority: if cont, grant last; else if req[other], grant other; else if req[last], grant last; else no grant.
- mN_waitrequest = reqN & ~grantN. An accepted beat is req & grant in the same cycle.
- A beat is accepted in the same cycle it is presented if granted. Back-to-back beats are allowed with no bubble.
- On a grant to g: if last_valid & g==last, hold_cnt <= sat(hold_cnt+1); else hold_cnt <= 0. Then last <= g and last_valid <= 1.
- On no grant: last_valid <= 0, hold_cnt <= 0, last holds its value. The next contest therefore prefers the master not served last.
- Memory mux: mem_address, mem_writedata and mem_write come from the granted master.
- mem_byteenable = granted master's byteenable on a write, all ones on a read.
- mem_chipselect = any grant. mem_clken = ~reset (1 in normal operation).
- Read return: rd_pend <= granted read; rd_owner <= g.
- mN_readdatavalid = rd_pend & (rd_owner==N), asserted the cycle after acceptance.
- mN_readdata = mem_readdata, broadcast to both masters; only readdatavalid qualifies it.
- At most one read is outstanding per cycle; reads are pipelined at one per cycle.
- Read after write: the same address accepted in the next cycle returns the new data. No hazard logic is needed.
- Reset mid-operation: any pending read is discarded; no readdatavalid is issued after reset deasserts.
- Idle master: no effect on state beyond the hold logic above.

Decomposition:
- Package mega_jsoc_mem_pkg holds ADDR_W/DATA_W defaults, BE_W derivation, and the owner encoding constants (OWN_M0=0, OWN_M1=1).
- Sub-module mega_jsoc_rr_grant contains the 2-way round-robin plus hold-counter grant logic and its registers.
- The top level holds the memory mux and the read-return pipeline.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 0x0010 with byteenable 0xF, then reads it. Expect m0_waitrequest=0 on both beats and m0_readdatavalid one cycle after the read with data 0xDEADBEEF.
- Both masters issue continuous reads (m0 at 0x0000+, m1 at 0x2000+), MAX_HOLD=4. Expect the grant pattern m0×4, m1×4, m0×4…, each readdatavalid to the correct master one cycle later, and no dropped beats.
- m1 requests alone for 10 beats. Expect no bubbles, hold_cnt saturated, m1_waitrequest=0 throughout.
- When m0 then requests, expect m0 to be granted on the next cycle.
- Byte-lane write: m0 writes 0x11223344 (be 0xF), then m1 writes 0xAABBCCDD with be 0x5 to the same address, then m0 reads. Expect 0x11BB33DD.
- Simultaneous first requests after idle (last=1 after reset): expect m0 granted first, m1_waitrequest=1 for that cycle, and m1 granted next.
- Assert reset the cycle after an accepted read. Expect no readdatavalid, waitrequest high during reset, and normal arbitration starting again from m0 after release.
